// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - op codes, opcode/funct constants and helpers for the instruction encoder
package instr_pkg;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_XOR   = 6'd4;
  localparam logic [5:0] OP_SLT   = 6'd5;
  localparam logic [5:0] OP_SLTU  = 6'd6;
  localparam logic [5:0] OP_SRA   = 6'd7;
  localparam logic [5:0] OP_SRL   = 6'd8;
  localparam logic [5:0] OP_SLL   = 6'd9;
  localparam logic [5:0] OP_MUL   = 6'd10;
  localparam logic [5:0] OP_ADDI  = 6'd11;
  localparam logic [5:0] OP_SUBI  = 6'd12;
  localparam logic [5:0] OP_ANDI  = 6'd13;
  localparam logic [5:0] OP_ORI   = 6'd14;
  localparam logic [5:0] OP_XORI  = 6'd15;
  localparam logic [5:0] OP_SLTI  = 6'd16;
  localparam logic [5:0] OP_SLTIU = 6'd17;
  localparam logic [5:0] OP_SRAI  = 6'd18;
  localparam logic [5:0] OP_SRLI  = 6'd19;
  localparam logic [5:0] OP_SLLI  = 6'd20;
  localparam logic [5:0] OP_LUI   = 6'd21;
  localparam logic [5:0] OP_AUIPC = 6'd22;
  localparam logic [5:0] OP_LW    = 6'd23;
  localparam logic [5:0] OP_SW    = 6'd24;
  localparam logic [5:0] OP_JR    = 6'd25;
  localparam logic [5:0] OP_JALR  = 6'd26;
  localparam logic [5:0] OP_JAL   = 6'd27;
  localparam logic [5:0] OP_BEQ   = 6'd28;
  localparam logic [5:0] OP_BNE   = 6'd29;
  localparam logic [5:0] OP_BLT   = 6'd30;
  localparam logic [5:0] OP_BGE   = 6'd31;
  localparam logic [5:0] OP_BLTU  = 6'd32;
  localparam logic [5:0] OP_BGEU  = 6'd33;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JUMP   = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SUBI = 3'b001;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LSW  = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_JAL  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] word;
  } enc_entry_t;

  // True when v, read as two's complement, fits in a signed field of the given width.
  function automatic logic fits_signed(input logic [31:0] v, input int bits);
    logic [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == 32'd0) || (s == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/instr_encode_if.sv
// rtl/instr_encode_if.sv - request/response handshake bundle of the instruction encoder
interface instr_encode_if #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [5:0]               in_op;
  logic [4:0]               in_rd;
  logic [4:0]               in_rs1;
  logic [4:0]               in_rs2;
  logic [31:0]              in_imm;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_instr;
  logic                     out_err;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic [CNT_W-1:0]         enc_count;
  logic [CNT_W-1:0]         err_count;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, fifo_level, enc_count, err_count
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, fifo_level, enc_count, err_count
  );
endinterface

// File: rtl/instr_enc_core.sv
// rtl/instr_enc_core.sv - combinational fields-to-word encoder; IMM_RANGE_CHECK_EN flags oversize immediates
module instr_enc_core
  import instr_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  logic [31:0] raw;
  logic        op_bad;

  always_comb begin
    raw    = 32'd0;
    op_bad = 1'b0;
    case (op)
      OP_ADD:   raw = {F7_ALT,  rs2, rs1, F3_ADD,  rd, OPC_R};
      OP_SUB:   raw = {F7_BASE, rs2, rs1, F3_ADD,  rd, OPC_R};
      OP_AND:   raw = {F7_BASE, rs2, rs1, F3_AND,  rd, OPC_R};
      OP_OR:    raw = {F7_BASE, rs2, rs1, F3_OR,   rd, OPC_R};
      OP_XOR:   raw = {F7_BASE, rs2, rs1, F3_XOR,  rd, OPC_R};
      OP_SLT:   raw = {F7_BASE, rs2, rs1, F3_SLT,  rd, OPC_R};
      OP_SLTU:  raw = {F7_BASE, rs2, rs1, F3_SLTU, rd, OPC_R};
      OP_SRA:   raw = {F7_ALT,  rs2, rs1, F3_SR,   rd, OPC_R};
      OP_SRL:   raw = {F7_BASE, rs2, rs1, F3_SR,   rd, OPC_R};
      OP_SLL:   raw = {F7_BASE, rs2, rs1, F3_SLL,  rd, OPC_R};
      OP_MUL:   raw = {F7_MUL,  rs2, rs1, F3_ADD,  rd, OPC_R};
      OP_ADDI:  raw = {imm[11:0], rs1, F3_ADD,  rd, OPC_I};
      OP_SUBI:  raw = {imm[11:0], rs1, F3_SUBI, rd, OPC_I};
      OP_ANDI:  raw = {imm[11:0], rs1, F3_AND,  rd, OPC_I};
      OP_ORI:   raw = {imm[11:0], rs1, F3_OR,   rd, OPC_I};
      OP_XORI:  raw = {imm[11:0], rs1, F3_XOR,  rd, OPC_I};
      OP_SLTI:  raw = {imm[11:0], rs1, F3_SLT,  rd, OPC_I};
      OP_SLTIU: raw = {imm[11:0], rs1, F3_SLTU, rd, OPC_I};
      OP_SRAI:  raw = {F7_ALT,  imm[4:0], rs1, F3_SR, rd, OPC_I};
      OP_SRLI:  raw = {F7_BASE, imm[4:0], rs1, F3_SR, rd, OPC_I};
      OP_SLLI:  raw = {F7_MUL,  imm[4:0], rs1, F3_SR, rd, OPC_I};
      OP_LUI:   raw = {imm[19:0], rd, OPC_LUI};
      OP_AUIPC: raw = {imm[19:0], rd, OPC_AUIPC};
      OP_LW:    raw = {imm[11:0], rs1, F3_LSW, rd, OPC_LOAD};
      OP_SW:    raw = {imm[11:5], rs2, rs1, F3_LSW, imm[4:0], OPC_STORE};
      OP_JR:    raw = {12'd0, rs1, 3'd0, 5'd0, OPC_JUMP};
      OP_JALR: begin
        raw    = {imm[11:0], rs1, F3_JALR, rd, OPC_JUMP};
        // rd=0 with a zero offset would decode back as jr
        op_bad = (rd == 5'd0) && (imm[11:0] == 12'd0);
      end
      OP_JAL:   raw = {imm[16:0], F3_JAL, rd, OPC_JUMP};
      OP_BEQ:   raw = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,  imm[4:1], imm[11], OPC_BRANCH};
      OP_BNE:   raw = {imm[12], imm[10:5], rs2, rs1, F3_BNE,  imm[4:1], imm[11], OPC_BRANCH};
      OP_BLT:   raw = {imm[12], imm[10:5], rs2, rs1, F3_BLT,  imm[4:1], imm[11], OPC_BRANCH};
      OP_BGE:   raw = {imm[12], imm[10:5], rs2, rs1, F3_BGE,  imm[4:1], imm[11], OPC_BRANCH};
      OP_BLTU:  raw = {imm[12], imm[10:5], rs2, rs1, F3_BLTU, imm[4:1], imm[11], OPC_BRANCH};
      OP_BGEU:  raw = {imm[12], imm[10:5], rs2, rs1, F3_BGEU, imm[4:1], imm[11], OPC_BRANCH};
      default:  op_bad = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic imm_ok;

  always_comb begin
    imm_ok = 1'b1;
    case (op)
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU,
      OP_LW, OP_SW, OP_JALR:
        imm_ok = fits_signed(imm, 12);
      OP_SRAI, OP_SRLI, OP_SLLI:
        imm_ok = (imm[31:5] == 27'd0);
      OP_LUI, OP_AUIPC:
        imm_ok = fits_signed(imm, 20);
      OP_JAL:
        imm_ok = fits_signed(imm, 17);
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
        imm_ok = fits_signed(imm, 13) && !imm[0];
      default:
        imm_ok = 1'b1;
    endcase
  end

  assign err = op_bad || !imm_ok;
`else
  logic unused_imm;
  assign unused_imm = ^imm[31:20];
  assign err = op_bad;
`endif

  assign word = err ? NOP_WORD : raw;

endmodule

// File: rtl/instr_encode.sv
// rtl/instr_encode.sv - instruction encoder with valid/ready handshake, output FIFO and saturating counters
module instr_encode
  import instr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_encode_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  enc_entry_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic [CNT_W-1:0] enc_cnt;
  logic [CNT_W-1:0] err_cnt;

  logic [31:0] core_word;
  logic        core_err;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  instr_enc_core u_core (
    .op   (bus.in_op),
    .rd   (bus.in_rd),
    .rs1  (bus.in_rs1),
    .rs2  (bus.in_rs2),
    .imm  (bus.in_imm),
    .word (core_word),
    .err  (core_err)
  );

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  // A full FIFO still accepts when the head is leaving in the same cycle
  assign bus.in_ready = !full || bus.out_ready;
  assign push  = bus.in_valid && bus.in_ready;
  assign pop   = bus.out_ready && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{err: core_err, word: core_word};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      enc_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (enc_cnt != CNT_MAX) begin
          enc_cnt <= enc_cnt + 1'b1;
        end
        if (core_err && (err_cnt != CNT_MAX)) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign bus.out_valid  = !empty;
  assign bus.out_instr  = empty ? 32'd0 : mem[rd_ptr].word;
  assign bus.out_err    = empty ? 1'b0  : mem[rd_ptr].err;
  assign bus.fifo_level = level;
  assign bus.enc_count  = enc_cnt;
  assign bus.err_count  = err_cnt;

endmodule

// File: tb/tb_instr_encode.sv
// tb/tb_instr_encode.sv - directed self-checking bench for instr_encode (IMM_RANGE_CHECK_EN aware)
module tb_instr_encode;
  import instr_pkg::*;

  localparam int DEPTH = 2;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encode_if #(.DEPTH(DEPTH), .CNT_W(CW)) bus ();

  instr_encode #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int enc_exp = 0;
  int err_exp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Counter expectation with saturation at 2**CW-1
  task automatic bump(input logic is_err);
    if (enc_exp < (1 << CW) - 1) enc_exp++;
    if (is_err && err_exp < (1 << CW) - 1) err_exp++;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
    bus.in_valid = 1'b1;
  endtask

  // Entered just after a rising edge with an empty FIFO and out_ready=1
  task automatic encode(input string tag, input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] exp_word, input logic exp_err);
    drive(op, rd, rs1, rs2, imm);
    @(negedge clk);
    check($sformatf("%s.in_ready", tag), 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bump(exp_err);
    @(negedge clk);
    check($sformatf("%s.valid", tag), 32'(bus.out_valid), 32'd1);
    check($sformatf("%s.instr", tag), bus.out_instr, exp_word);
    check($sformatf("%s.err", tag), 32'(bus.out_err), 32'(exp_err));
    check($sformatf("%s.enc_count", tag), 32'(bus.enc_count), 32'(enc_exp));
    check($sformatf("%s.err_count", tag), 32'(bus.err_count), 32'(err_exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_instr", bus.out_instr, 32'd0);
    check("rst.out_err", 32'(bus.out_err), 32'd0);
    check("rst.fifo_level", 32'(bus.fifo_level), 32'd0);
    check("rst.enc_count", 32'(bus.enc_count), 32'd0);
    check("rst.err_count", 32'(bus.err_count), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;

    encode("add",   OP_ADD,   5'd3,  5'd1,  5'd2,  32'd0,        32'h402081B3, 1'b0);
    encode("ill40", 6'd40,    5'd3,  5'd1,  5'd2,  32'd0,        32'h00000013, 1'b1);
    encode("sub",   OP_SUB,   5'd1,  5'd2,  5'd3,  32'd0,        32'h003100B3, 1'b0);
    encode("sra",   OP_SRA,   5'd4,  5'd5,  5'd6,  32'd0,        32'h4062D233, 1'b0);
    encode("mul",   OP_MUL,   5'd10, 5'd11, 5'd12, 32'd0,        32'h02C58533, 1'b0);
    encode("addi",  OP_ADDI,  5'd5,  5'd0,  5'd0,  32'hFFFFFFFF, 32'hFFF00293, 1'b0);
    encode("srai",  OP_SRAI,  5'd7,  5'd8,  5'd0,  32'd3,        32'h40345393, 1'b0);
    encode("slli",  OP_SLLI,  5'd1,  5'd1,  5'd0,  32'd31,       32'h03F0D093, 1'b0);
    encode("lui",   OP_LUI,   5'd1,  5'd0,  5'd0,  32'h00012345, 32'h123450B7, 1'b0);
    encode("auipc", OP_AUIPC, 5'd2,  5'd0,  5'd0,  32'hFFFFFFFF, 32'hFFFFF117, 1'b0);
    encode("lw",    OP_LW,    5'd6,  5'd2,  5'd0,  32'd8,        32'h00812303, 1'b0);
    encode("sw",    OP_SW,    5'd0,  5'd2,  5'd9,  32'hFFFFFFFC, 32'hFE912E23, 1'b0);
    encode("jr",    OP_JR,    5'd5,  5'd1,  5'd7,  32'd100,      32'h0000806F, 1'b0);
    encode("jalr",  OP_JALR,  5'd1,  5'd2,  5'd0,  32'd4,        32'h004100EF, 1'b0);
    encode("jal",   OP_JAL,   5'd1,  5'd0,  5'd0,  32'h00000100, 32'h008070EF, 1'b0);
    encode("beq",   OP_BEQ,   5'd0,  5'd1,  5'd2,  32'd8,        32'h00208463, 1'b0);
    encode("bgeu",  OP_BGEU,  5'd0,  5'd3,  5'd4,  32'hFFFFFFFE, 32'hFE41FFE3, 1'b0);
    encode("alias", OP_JALR,  5'd0,  5'd5,  5'd0,  32'd0,        32'h00000013, 1'b1);
`ifdef IMM_RANGE_CHECK_EN
    encode("imm2048", OP_ADDI, 5'd0, 5'd0,  5'd0,  32'd2048,     32'h00000013, 1'b1);
`else
    encode("imm2048", OP_ADDI, 5'd0, 5'd0,  5'd0,  32'd2048,     32'h80000013, 1'b0);
`endif

    // Backpressure: fill the FIFO, then pop and push in the same cycle
    bus.out_ready = 1'b0;
    drive(OP_ADD, 5'd1, 5'd0, 5'd0, 32'd0);
    @(posedge clk);
    #1 drive(OP_ADD, 5'd2, 5'd0, 5'd0, 32'd0);
    bump(1'b0);
    @(posedge clk);
    #1 drive(OP_ADD, 5'd3, 5'd0, 5'd0, 32'd0);
    bump(1'b0);
    @(negedge clk);
    check("bp.in_ready_full", 32'(bus.in_ready), 32'd0);
    check("bp.level_full", 32'(bus.fifo_level), 32'd2);
    check("bp.head_a", bus.out_instr, 32'h400000B3);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp.in_ready_pop", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bump(1'b0);
    @(negedge clk);
    check("bp.level_pushpop", 32'(bus.fifo_level), 32'd2);
    check("bp.head_b", bus.out_instr, 32'h40000133);
    check("bp.enc_count", 32'(bus.enc_count), 32'(enc_exp));
    @(posedge clk);
    @(negedge clk);
    check("bp.head_c", bus.out_instr, 32'h400001B3);
    check("bp.level_1", 32'(bus.fifo_level), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("bp.level_0", 32'(bus.fifo_level), 32'd0);
    check("bp.empty_valid", 32'(bus.out_valid), 32'd0);
    check("bp.empty_instr", bus.out_instr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp.pop_empty_level", 32'(bus.fifo_level), 32'd0);

    // Reset with two entries held
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    drive(OP_SUB, 5'd1, 5'd1, 5'd1, 32'd0);
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid.level_before", 32'(bus.fifo_level), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid.out_valid", 32'(bus.out_valid), 32'd0);
    check("mid.fifo_level", 32'(bus.fifo_level), 32'd0);
    check("mid.enc_count", 32'(bus.enc_count), 32'd0);
    check("mid.err_count", 32'(bus.err_count), 32'd0);
    check("mid.out_instr", bus.out_instr, 32'd0);
    enc_exp = 0;
    err_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    encode("post_rst", OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_encode.md
Name: instr_encode

Overview:
- Inverse of the team's ALU-select decoder: accepts an operation code in the same 6-bit alu_select enumeration, plus register and immediate fields.
- Emits the 32-bit instruction word that the decoder maps back to the same code.
- Used by the self-test instruction generator to fill instruction memory.
- Valid/ready on both sides, DEPTH-entry output FIFO, running counters.

Parameters:
- DEPTH, 2, output FIFO entries (power of 2, min 2).
- CNT_W, 16, width of enc_count/err_count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&in_ready.
- in_op  in  6  alu_select code 0..33.
- in_rd  in  5  destination reg.
- in_rs1  in  5  source reg 1.
- in_rs2  in  5  source reg 2.
- in_imm  in  32  signed immediate, LSB-aligned.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pop.
- out_instr  out  32  encoded word (FIFO head).
- out_err  out  1  head entry illegal.
- fifo_level  out  $clog2(DEPTH)+1  occupancy.
- enc_count  out  CNT_W  accepted requests.
- err_count  out  CNT_W  accepted requests flagged illegal.

Behaviour:
- Reset: FIFO empty; out_valid=0, out_instr=0, out_err=0, fifo_level=0, counters=0.
- in_ready = !full || out_ready (pop and push in the same cycle allowed when full).
- Latency: word accepted at edge N is visible at head after edge N when the FIFO was empty; order is preserved.
- Push and pop in the same cycle: level unchanged. Pop when empty is ignored. Push when full and no pop is impossible because in_ready=0.
- Pointers wrap modulo DEPTH.
- Counters increment on accept and saturate at all-ones.
- Encoding, fields {f7[31:25], rs2[24:20], rs1[19:15], f3[14:12], rd[11:7], opc[6:0]}:
  - R-type, opc 0110011, f3/f7 per op:
    - add f7=0100000 f3=000; sub 0000000/000; and /111; or /110; xor /100; slt /010; sltu /011; sra 0100000/101; srl 0000000/101; sll 0000000/001; mul 0000001/000.
  - I-type, opc 0010011, imm[11:0] at [31:20]:
    - f3: addi 000, subi 001, andi 111, ori 110, xori 100, slti 010, sltiu 011.
    - srai/srli/slli: f3=101, f7=0100000/0000000/0000001, imm[4:0] at [24:20].
  - lui opc 0110111, auipc opc 0010111: imm[19:0] at [31:12], rd.
  - lw: opc 0000011, f3 010, I layout.
  - sw: opc 0100011, f3 010, imm[11:5] at [31:25], imm[4:0] at [11:7].
  - Jump group, opc 1101111:
    - jr: rs1 only, all other bits 0.
    - jalr: f3=000, rd, rs1, imm[11:0] at [31:20].
    - jal: f3=111, rd, imm[16:0] at [31:15].
  - Branches, opc 1100011, standard B layout of imm[12:1]: f3 beq 000, bne 001, blt 100, bge 101, bltu 110, bgeu 111.
- Illegal, which sets the error bit, pushes 0x00000013 and increments err_count:
  - in_op > 33.
  - jalr with rd=0 and imm[11:0]=0, because it aliases jr.
- Reset mid-stream: FIFO contents and counters are discarded immediately.

Optional Feature:
- IMM_RANGE_CHECK_EN defined: an in_imm that does not sign-fit its field is flagged illegal and handled as above.
  - Fields: 12b I/S, 13b even B, 20b U, 17b jal, 5b unsigned shamt.
- Undefined: out-of-range immediates are truncated silently, with no error.

Decomposition:
- Package instr_pkg: localparams for all 34 op codes, the 7-bit opcode constants, f3/f7 constants, and the NOP word.
- Sub-module instr_enc_core: purely combinational fields -> {word, err}.
- instr_encode adds the FIFO, handshake and counters around it.

Test Plan:
- Case 1, add:
  - Stimulus: op 0, rd3, rs1=1, rs2=2, out_ready=1.
  - Response: out_instr 0x402081B3, err 0, one cycle after accept.
- Case 2, addi:
  - Stimulus: op 11, rd5, rs1=0, imm -1.
  - Response: 0xFFF00293. lui (op 21) rd1 imm 0x12345 -> 0x123450B7.
- Case 3, illegal op:
  - Stimulus: op 40.
  - Response: 0x00000013, out_err 1, err_count 1, enc_count 1.
- Case 4, backpressure:
  - Stimulus: out_ready=0, push 3 requests.
  - Response: in_ready drops after 2 and fifo_level=2. Raise out_ready with in_valid held -> simultaneous push/pop, level stays 2, order preserved.
- Case 5, alias and range:
  - Stimulus: jalr rd0 imm0.
  - Response: flagged illegal.
  - Stimulus: addi imm 2048 with IMM_RANGE_CHECK_EN.
  - Response: err 1; without the macro, imm field 0x800, err 0.
- Case 6, reset mid-stream:
  - Stimulus: assert rst_n=0 with the FIFO holding 2 entries.
  - Response: out_valid, fifo_level and counters go to 0 before the next edge.
